// File: rtl/interp_filt_pkg.sv
// Shared constants and helpers for the interpolation filter datapath.
// Provides default widths, the rounding constant helper and a signed clamp.
package interp_filt_pkg;

   localparam int unsigned DATA_WIDTH_DEF      = 6;
   localparam int unsigned TAP_COEFF_WIDTH_DEF = 6;
   localparam int unsigned NUM_LANES_DEF       = 4;

   // Half an LSB of the result, expressed in product units: 2^(coeff_w-2).
   function automatic int unsigned ROUND_HALF(input int unsigned coeff_w);
      return 32'd1 << (coeff_w - 32'd2);
   endfunction

   // Clamp a signed value into the signed range of a w-bit word.
   function automatic logic signed [31:0] saturate(input logic signed [31:0] x,
                                                   input int unsigned        w);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = $signed((32'd1 << (w - 32'd1)) - 32'd1);
      lo = -hi - 32'sd1;
      if (x > hi) begin
         return hi;
      end
      if (x < lo) begin
         return lo;
      end
      return x;
   endfunction

endpackage

// File: rtl/mult_lane.sv
// One multiplier lane: S1 registers the full signed product, S2 rounds,
// shifts back to the sample format, narrows and registers the result.
// Build option MULT_SAT_EN: clamp on narrowing and keep a sticky overflow flag.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   s1_en_i, s2_en_i  stage load enables (from top valid/ready control)
//   s1_round_i        round_en captured alongside the S1 product
//   in_data_i         sample, signed Q1.(DATA_WIDTH-1)
//   coeff_i           coefficient, signed Q1.(TAP_COEFF_WIDTH-1)
//   out_data_o        registered result
//   sat_clr_i         (MULT_SAT_EN) synchronous flag clear
//   sat_flag_o        (MULT_SAT_EN) sticky overflow flag
module mult_lane
   import interp_filt_pkg::*;
#(
   parameter int unsigned DATA_WIDTH      = DATA_WIDTH_DEF,
   parameter int unsigned TAP_COEFF_WIDTH = TAP_COEFF_WIDTH_DEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       s1_en_i,
   input  logic                       s2_en_i,
   input  logic                       s1_round_i,
   input  logic [DATA_WIDTH-1:0]      in_data_i,
   input  logic [TAP_COEFF_WIDTH-1:0] coeff_i,
`ifdef MULT_SAT_EN
   input  logic                       sat_clr_i,
   output logic                       sat_flag_o,
`endif
   output logic [DATA_WIDTH-1:0]      out_data_o
);

   localparam int unsigned PW = DATA_WIDTH + TAP_COEFF_WIDTH;
   localparam int unsigned SH = TAP_COEFF_WIDTH - 1;

   logic signed [PW-1:0]     p_d;
   logic signed [PW-1:0]     p_q;
   logic signed [PW-1:0]     rnd_c;
   logic [DATA_WIDTH-1:0]    out_d;
   logic [DATA_WIDTH-1:0]    out_q;

   // S1: full-precision signed product.
   always_comb begin
      p_d = PW'($signed(in_data_i)) * PW'($signed(coeff_i));
   end

   always_comb begin
      rnd_c = s1_round_i ? PW'(ROUND_HALF(TAP_COEFF_WIDTH)) : '0;
   end

`ifdef MULT_SAT_EN
   logic signed [PW-1:0] q_c;
   logic signed [31:0]   sat_c;
   logic                 clamp_c;
   logic                 sat_flag_d;
   logic                 sat_flag_q;

   // S2: round, arithmetic shift, clamp into the sample range.
   always_comb begin
      q_c     = (p_q + rnd_c) >>> SH;
      sat_c   = saturate(32'(q_c), DATA_WIDTH);
      out_d   = DATA_WIDTH'(sat_c);
      clamp_c = (32'(q_c) != sat_c);
   end

   // Sticky flag: a set in the same cycle as a clear wins.
   always_comb begin
      sat_flag_d = sat_flag_q;
      if (sat_clr_i) begin
         sat_flag_d = 1'b0;
      end
      if (s2_en_i && clamp_c) begin
         sat_flag_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_flag_q <= 1'b0;
      end else begin
         sat_flag_q <= sat_flag_d;
      end
   end

   assign sat_flag_o = sat_flag_q;
`else
   // S2: round, arithmetic shift, keep the low bits (wrapping).
   always_comb begin
      out_d = DATA_WIDTH'((p_q + rnd_c) >>> SH);
   end
`endif

   // Stage registers load only when their stage advances with a real beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q   <= '0;
         out_q <= '0;
      end else begin
         if (s1_en_i) begin
            p_q <= p_d;
         end
         if (s2_en_i) begin
            out_q <= out_d;
         end
      end
   end

   assign out_data_o = out_q;

endmodule

// File: rtl/mult_pipe.sv
// Pipelined multi-lane signed fractional multiplier with valid/ready on both
// sides. Two register stages (product, rounded result); bubbles collapse.
// Build option MULT_SAT_EN: saturating narrowing plus sat_flag/sat_clr ports.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   in_valid/in_ready      input handshake (in_ready depends on out_ready)
//   in_data, tap_coeff     packed lanes, lane i at [i*W +: W]
//   round_en               1 = round half up, 0 = truncate; taken with the beat
//   out_valid/out_ready    output handshake
//   out_data               packed lane results
//   sat_flag, sat_clr      (MULT_SAT_EN) sticky per-lane overflow, clear
module mult_pipe
   import interp_filt_pkg::*;
#(
   parameter int unsigned DATA_WIDTH      = DATA_WIDTH_DEF,
   parameter int unsigned TAP_COEFF_WIDTH = TAP_COEFF_WIDTH_DEF,
   parameter int unsigned NUM_LANES       = NUM_LANES_DEF
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [NUM_LANES*DATA_WIDTH-1:0]      in_data,
   input  logic [NUM_LANES*TAP_COEFF_WIDTH-1:0] tap_coeff,
   input  logic                                 round_en,
   output logic                                 out_valid,
   input  logic                                 out_ready,
`ifdef MULT_SAT_EN
   output logic [NUM_LANES-1:0]                 sat_flag,
   input  logic                                 sat_clr,
`endif
   output logic [NUM_LANES*DATA_WIDTH-1:0]      out_data
);

   logic s1_valid_d;
   logic s1_valid_q;
   logic s2_valid_d;
   logic s2_valid_q;
   logic round_d;
   logic round_q;
   logic s1_adv_c;
   logic s2_adv_c;
   logic s1_load_c;
   logic s2_load_c;

   // Stall control: each stage moves when it is empty or its successor moves.
   always_comb begin
      s2_adv_c  = !s2_valid_q || out_ready;
      s1_adv_c  = !s1_valid_q || s2_adv_c;
      s1_load_c = s1_adv_c && in_valid;
      s2_load_c = s2_adv_c && s1_valid_q;
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s2_valid_d = s2_valid_q;
      round_d    = round_q;
      if (s1_adv_c) begin
         s1_valid_d = in_valid;
      end
      if (s2_adv_c) begin
         s2_valid_d = s1_valid_q;
      end
      if (s1_load_c) begin
         round_d = round_en;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         round_q    <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         round_q    <= round_d;
      end
   end

   assign in_ready  = s1_adv_c;
   assign out_valid = s2_valid_q;

   // Independent lanes sharing one valid.
   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      mult_lane #(
         .DATA_WIDTH      (DATA_WIDTH),
         .TAP_COEFF_WIDTH (TAP_COEFF_WIDTH)
      ) u_lane (
         .clk        (clk),
         .rst_n      (rst_n),
         .s1_en_i    (s1_load_c),
         .s2_en_i    (s2_load_c),
         .s1_round_i (round_q),
         .in_data_i  (in_data[g*DATA_WIDTH +: DATA_WIDTH]),
         .coeff_i    (tap_coeff[g*TAP_COEFF_WIDTH +: TAP_COEFF_WIDTH]),
`ifdef MULT_SAT_EN
         .sat_clr_i  (sat_clr),
         .sat_flag_o (sat_flag[g]),
`endif
         .out_data_o (out_data[g*DATA_WIDTH +: DATA_WIDTH])
      );
   end

endmodule
